// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes the ALU operation, selects operands and buffers
// one instruction plus one skid entry so in_ready is registered.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] imm,
  input  logic        alu_src,
  input  logic [1:0]  op_cls,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] in1,
  output logic [63:0] in2,
  output logic [3:0]  ALUop,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        illegal
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 5;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_ILL = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0]  in1;
    logic [XLEN-1:0]  in2;
    logic [OP_W-1:0]  aluop;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             illegal;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry_c;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic [OP_W-1:0] dec_aluop_c;
  logic   accept_c;
  logic   main_free_c;

  // ALU operation decode from instruction class and function bits
  always_comb begin
    dec_aluop_c = OP_ILL;
    case (op_cls)
      2'b00: dec_aluop_c = OP_ADD;
      2'b01: dec_aluop_c = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_aluop_c = funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  dec_aluop_c = OP_AND;
          3'b110:  dec_aluop_c = OP_OR;
          default: dec_aluop_c = OP_ILL;
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  dec_aluop_c = OP_ADD;
          3'b111:  dec_aluop_c = OP_AND;
          3'b110:  dec_aluop_c = OP_OR;
          default: dec_aluop_c = OP_ILL;
        endcase
      end
    endcase
  end

  // Incoming entry with operand select and illegal write suppression
  always_comb begin
    in_entry_c.in1       = rs1_data;
    in_entry_c.in2       = alu_src ? imm : rs2_data;
    in_entry_c.aluop     = dec_aluop_c;
    in_entry_c.rd        = rd;
    in_entry_c.illegal   = (dec_aluop_c == OP_ILL);
    in_entry_c.reg_write = reg_write & (dec_aluop_c != OP_ILL);
  end

  assign accept_c    = in_valid & in_ready_q & ~flush;
  assign main_free_c = ~main_valid_q | out_ready;

  // Main/skid next state; the skid only fills while main is held
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free_c) begin
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
      end else if (accept_c) begin
        main_d       = in_entry_c;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_d       = in_entry_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign in1           = main_q.in1;
  assign in2           = main_q.in2;
  assign ALUop         = main_q.aluop;
  assign rd_out        = main_q.rd;
  assign reg_write_out = main_q.reg_write;
  assign illegal       = main_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a two-deep FIFO reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] rs1_data, rs2_data, imm;
  logic        alu_src;
  logic [1:0]  op_cls;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic        reg_write, flush;
  logic        out_valid, out_ready;
  logic [63:0] in1, in2;
  logic [3:0]  ALUop;
  logic [4:0]  rd_out;
  logic        reg_write_out, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } m_entry_t;

  m_entry_t m_q[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .op_cls(op_cls), .funct3(funct3), .funct7_5(funct7_5), .rd(rd),
    .reg_write(reg_write), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .in1(in1), .in2(in2), .ALUop(ALUop),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_op(logic [1:0] oc, logic [2:0] f3, logic f7);
    if (oc == 2'b00) return 4'd2;
    if (oc == 2'b01) return 4'd6;
    if (f3 == 3'd0) return (oc == 2'b10 && f7) ? 4'd6 : 4'd2;
    if (f3 == 3'd7) return 4'd0;
    if (f3 == 3'd6) return 4'd1;
    return 4'd15;
  endfunction

  function automatic m_entry_t mk_entry();
    m_entry_t e;
    e.a   = rs1_data;
    e.b   = alu_src ? imm : rs2_data;
    e.op  = ref_op(op_cls, funct3, funct7_5);
    e.ill = (e.op == 4'd15);
    e.rw  = reg_write && !e.ill;
    e.rd  = rd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    m_entry_t e;
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    if (m_q.size() > 0) begin
      e = m_q[0];
      chk("in1", in1, e.a);
      chk("in2", in2, e.b);
      chk("ALUop", 64'(ALUop), 64'(e.op));
      chk("rd_out", 64'(rd_out), 64'(e.rd));
      chk("reg_write_out", 64'(reg_write_out), 64'(e.rw));
      chk("illegal", 64'(illegal), 64'(e.ill));
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare
  task automatic step();
    int sz;
    bit take;
    @(posedge clk);
    sz = m_q.size();
    if (flush) begin
      m_q.delete();
    end else begin
      take = in_valid && (sz < 2);
      if (sz > 0 && out_ready) void'(m_q.pop_front());
      if (take) m_q.push_back(mk_entry());
    end
    #1;
    compare();
  endtask

  task automatic set_in(input logic v, input logic [1:0] oc, input logic [2:0] f3,
                        input logic f7, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] im, input logic src, input logic [4:0] r,
                        input logic rw);
    in_valid = v; op_cls = oc; funct3 = f3; funct7_5 = f7;
    rs1_data = a; rs2_data = b; imm = im; alu_src = src; rd = r; reg_write = rw;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_in1"}, in1, 64'd0);
    chk({tag, "_in2"}, in2, 64'd0);
    chk({tag, "_ALUop"}, 64'(ALUop), 64'd0);
    chk({tag, "_rd_out"}, 64'(rd_out), 64'd0);
    chk({tag, "_rw_out"}, 64'(reg_write_out), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 2'b00, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_reset_vals("por");
    #2 rst = 1'b0;

    // R-type ADD and SUB, I-type AND with immediate
    set_in(1'b1, 2'b10, 3'b000, 1'b0, 64'd10, 64'd12, 64'd99, 1'b0, 5'd3, 1'b1);
    step();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_in1", in1, 64'd10);
    chk("add_in2", in2, 64'd12);
    chk("add_op", 64'(ALUop), 64'b0010);
    set_in(1'b1, 2'b10, 3'b000, 1'b1, 64'd15, 64'd10, 64'd0, 1'b0, 5'd4, 1'b1);
    step();
    chk("sub_op", 64'(ALUop), 64'b0110);
    chk("sub_in1", in1, 64'd15);
    set_in(1'b1, 2'b11, 3'b111, 1'b0, 64'd7, 64'd55, 64'd12, 1'b1, 5'd5, 1'b1);
    step();
    chk("andi_in2", in2, 64'd12);
    chk("andi_op", 64'(ALUop), 64'b0000);
    // Illegal R-type funct3=001 suppresses the register write
    set_in(1'b1, 2'b10, 3'b001, 1'b0, 64'd1, 64'd2, 64'd0, 1'b0, 5'd6, 1'b1);
    step();
    chk("ill_op", 64'(ALUop), 64'b1111);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_rw", 64'(reg_write_out), 64'd0);
    in_valid = 1'b0;
    step();
    chk("drained", 64'(out_valid), 64'd0);

    // Backpressure: A held, B skid, C refused, then drain in order
    out_ready = 1'b0;
    set_in(1'b1, 2'b00, 3'd0, 1'b0, 64'hA, 64'd0, 64'd0, 1'b0, 5'd10, 1'b1);
    step();
    set_in(1'b1, 2'b00, 3'd0, 1'b0, 64'hB, 64'd0, 64'd0, 1'b0, 5'd11, 1'b1);
    step();
    chk("bp_hold_a", in1, 64'hA);
    chk("bp_not_ready", 64'(in_ready), 64'd0);
    set_in(1'b1, 2'b00, 3'd0, 1'b0, 64'hC, 64'd0, 64'd0, 1'b0, 5'd12, 1'b1);
    step();
    chk("bp_still_a", in1, 64'hA);
    chk("bp_c_refused", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_b_next", in1, 64'hB);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_c_next", in1, 64'hC);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with both entries full drops everything including the new input
    out_ready = 1'b0;
    set_in(1'b1, 2'b01, 3'd0, 1'b0, 64'h11, 64'h1, 64'd0, 1'b0, 5'd1, 1'b1);
    step();
    rs1_data = 64'h22;
    step();
    rs1_data = 64'h33; flush = 1'b1; out_ready = 1'b1;
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl_dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset with entries held
    out_ready = 1'b0;
    set_in(1'b1, 2'b10, 3'b110, 1'b0, 64'h44, 64'h5, 64'd0, 1'b0, 5'd9, 1'b1);
    step();
    rs1_data = 64'h55;
    step();
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    m_q.delete();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    step();
    chk("arst_empty", 64'(out_valid), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 2) != 0), 2'($urandom), 3'($urandom),
             1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 1'($urandom), 5'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  in_valid  in  1  decode stage presents an instruction
  in_ready  out  1  stage can accept; registered
  rs1_data  in  64  register-file read port 1
  rs2_data  in  64  register-file read port 2
  imm  in  64  sign-extended immediate
  alu_src  in  1  0 selects rs2_data, 1 selects imm for in2
  op_cls  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
  funct3  in  3  instruction funct3
  funct7_5  in  1  instruction bit 30
  rd  in  5  destination register
  reg_write  in  1  instruction writes rd
  flush  in  1  discard all held instructions
  out_valid  out  1  ALU operands valid
  out_ready  in  1  execute stage consumes this cycle
  in1  out  64  ALU operand 1
  in2  out  64  ALU operand 2
  ALUop  out  4  ALU operation code
  rd_out  out  5  registered rd
  reg_write_out  out  1  registered reg_write, forced 0 when illegal
  illegal  out  1  unsupported op_cls/funct combination

Function
REQ-003 ALUop encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 illegal.
REQ-004 Decode: op_cls 00 -> 0010; op_cls 01 -> 0110; funct3 and funct7_5 ignored for both.
REQ-005 Decode op_cls 10: funct3 000 with funct7_5=0 -> 0010, with funct7_5=1 -> 0110; 111 -> 0000; 110 -> 0001; any other -> 1111.
REQ-006 Decode op_cls 11: funct3 000 -> 0010; 111 -> 0000; 110 -> 0001; any other -> 1111; funct7_5 ignored.
REQ-007 illegal SHALL be 1 exactly when ALUop is 1111; reg_write_out SHALL be 0 whenever illegal=1.
REQ-008 Capture: in1 = rs1_data; in2 = imm if alu_src=1 else rs2_data; width 64, no modification.
REQ-009 Storage: a main register (drives outputs) and one skid register, each with a valid bit.
REQ-010 Transfer in: occurs when in_valid && in_ready && !flush on a rising edge.
REQ-011 Transfer out: occurs when out_valid && out_ready on a rising edge.
REQ-012 Latency: an input accepted while main is empty or being drained SHALL appear on outputs with out_valid=1 the next cycle (1 cycle).
REQ-013 Backpressure: input accepted while main is held (out_valid && !out_ready) SHALL go to skid; in_ready SHALL be 0 the next cycle.
REQ-014 On transfer out with skid valid, main SHALL load skid, skid SHALL clear, and in_ready SHALL return to 1 the next cycle.
REQ-015 in_ready SHALL equal !skid_valid as registered state; no combinational path from out_ready to in_ready.
REQ-016 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-017 Order SHALL be preserved; no instruction duplicated or dropped except by flush.
REQ-018 flush SHALL clear both valid bits on the next edge; input presented the same cycle is dropped; flush overrides out_ready.
REQ-019 Data fields of invalid entries are don't-care except after reset.

Reset
REQ-020 While rst=1 (asynchronously): out_valid=0, skid cleared, in_ready=1, in1=in2=0, ALUop=0000, rd_out=0, reg_write_out=0, illegal=0.
REQ-021 Reset mid-operation SHALL discard both entries; the first edge after deassert behaves as the empty state.

Verification
REQ-022 R-type, rs1=10, rs2=12, funct3=000, f7_5=0, out_ready=1 -> next cycle out_valid=1, in1=10, in2=12, ALUop=0010.
REQ-023 Same with rs1=15, rs2=10, f7_5=1 -> ALUop=0110; I-type funct3=111, imm=12 -> in2=12, ALUop=0000.
REQ-024 out_ready=0, three back-to-back inputs A,B,C -> A held, B in skid, in_ready=0, C not accepted; then out_ready=1 -> A, B, C emerge in order, one per cycle.
REQ-025 R-type funct3=001, reg_write=1 -> ALUop=1111, illegal=1, reg_write_out=0.
REQ-026 Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
REQ-027 rst pulsed mid-cycle with entries held -> out_valid=0 and all REQ-020 values immediately, before next clk edge.
